// File: rtl/irq_gen_if.sv
// Interrupt generator bus: per-channel enable/event/EOI in, IRQ/pending lines out.
// With IRQ_GEN_OVF_EN defined, the bus also carries the OVF flags and the OVF_CLR strobes.
interface irq_gen_if #(
  parameter int NUM_IRQ = 8
);
  logic [NUM_IRQ-1:0] EN;
  logic [NUM_IRQ-1:0] EVT;
  logic [NUM_IRQ-1:0] EOI;
  logic [NUM_IRQ-1:0] IRQOUT;
  logic [NUM_IRQ-1:0] PEND;
`ifdef IRQ_GEN_OVF_EN
  logic [NUM_IRQ-1:0] OVF;
  logic [NUM_IRQ-1:0] OVF_CLR;

  modport master (output EN, EVT, EOI, OVF_CLR, input IRQOUT, PEND, OVF);
  modport slave  (input EN, EVT, EOI, OVF_CLR, output IRQOUT, PEND, OVF);
`else
  modport master (output EN, EVT, EOI, input IRQOUT, PEND);
  modport slave  (input EN, EVT, EOI, output IRQOUT, PEND);
`endif
endinterface

// File: rtl/irq_gen.sv
// irq_gen: turns per-channel event edges into level IRQs with a minimum high time,
// EOI-gated release and a minimum low gap. Define IRQ_GEN_OVF_EN for sticky overflow flags.
module irq_gen #(
  parameter int NUM_IRQ  = 8,
  parameter int HOLD_MIN = 2,
  parameter int GAP_MIN  = 2
) (
  input logic      CLK,
  input logic      RSTn,
  irq_gen_if.slave irq
);
  localparam int CNT_MAX = (HOLD_MIN > GAP_MIN) ? HOLD_MIN : GAP_MIN;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MIN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_MIN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  // Low for the first cycle after reset: a level already high at release is not an edge.
  logic armed_reg;
  always_ff @(posedge CLK) begin
    if (!RSTn) armed_reg <= 1'b0;
    else       armed_reg <= 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_ch
      state_t           state_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             eoi_seen_reg;
      logic             irq_reg;
      logic             pend_reg;
      logic             evt_d_reg;
      logic             evt_rise;
      logic             issue;

      assign evt_rise = irq.EVT[gi] & ~evt_d_reg & irq.EN[gi] & armed_reg;
      assign issue    = (state_reg == IDLE) & pend_reg;

      always_ff @(posedge CLK) begin
        if (!RSTn) begin
          state_reg    <= IDLE;
          cnt_reg      <= '0;
          eoi_seen_reg <= 1'b0;
          irq_reg      <= 1'b0;
          pend_reg     <= 1'b0;
          evt_d_reg    <= 1'b0;
        end else begin
          evt_d_reg <= irq.EVT[gi];
          if (!irq.EN[gi]) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            eoi_seen_reg <= 1'b0;
            irq_reg      <= 1'b0;
            pend_reg     <= 1'b0;
          end else begin
            // A rise on the issuing edge re-queues rather than being dropped.
            pend_reg <= evt_rise | (pend_reg & ~issue);
            case (state_reg)
              IDLE: begin
                if (pend_reg) begin
                  state_reg <= ASSERT;
                  cnt_reg   <= '0;
                  irq_reg   <= 1'b1;
                end
              end
              ASSERT: begin
                if (cnt_reg == HOLD_LAST && (eoi_seen_reg || irq.EOI[gi])) begin
                  state_reg    <= HOLDOFF;
                  cnt_reg      <= '0;
                  eoi_seen_reg <= 1'b0;
                  irq_reg      <= 1'b0;
                end else begin
                  if (cnt_reg != HOLD_LAST) cnt_reg <= cnt_reg + CNT_ONE;
                  if (irq.EOI[gi]) eoi_seen_reg <= 1'b1;
                end
              end
              HOLDOFF: begin
                if (cnt_reg == GAP_LAST) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
                end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
                end
              end
              default: begin
                state_reg    <= IDLE;
                cnt_reg      <= '0;
                eoi_seen_reg <= 1'b0;
                irq_reg      <= 1'b0;
              end
            endcase
          end
        end
      end

      assign irq.IRQOUT[gi] = irq_reg;
      assign irq.PEND[gi]   = pend_reg;

`ifdef IRQ_GEN_OVF_EN
      logic ovf_reg;
      // Set only when a rise merges into a request that is not leaving PEND this edge.
      always_ff @(posedge CLK) begin
        if (!RSTn) ovf_reg <= 1'b0;
        else       ovf_reg <= (ovf_reg & ~irq.OVF_CLR[gi]) | (evt_rise & pend_reg & ~issue);
      end
      assign irq.OVF[gi] = ovf_reg;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_irq_gen.sv
// Self-checking bench for irq_gen: directed scenarios then random traffic, every cycle
// compared against a timestamp-based reference model of the request/EOI/gap rules.
module tb_irq_gen;
  localparam int N    = 8;
  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  irq_gen_if #(.NUM_IRQ(N)) bus ();

  irq_gen #(.NUM_IRQ(N), .HOLD_MIN(HOLD), .GAP_MIN(GAP)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .irq  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per channel, when it last rose, earliest edge a new rise is allowed.
  bit m_hi[N], m_pend[N], m_ack[N], m_ovf[N], m_prev[N];
  int m_rise_at[N], m_ok_at[N];
  bit m_armed = 1'b0;
  int cyc = 0;
  logic [N-1:0] exp_irq, exp_pend, exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] en, input logic [N-1:0] evt,
                            input logic [N-1:0] eoi, input logic rstn, input logic [N-1:0] oclr);
    for (int i = 0; i < N; i++) begin
      bit rise, issue;
      if (!rstn) begin
        m_hi[i] = 0; m_pend[i] = 0; m_ack[i] = 0; m_ovf[i] = 0; m_prev[i] = 0;
        m_ok_at[i] = 0;
      end else begin
        rise = m_armed && en[i] && evt[i] && !m_prev[i];
        m_prev[i] = evt[i];
        issue = en[i] && !m_hi[i] && m_pend[i] && (cyc >= m_ok_at[i]);
        m_ovf[i] = (m_ovf[i] && !oclr[i]) || (rise && m_pend[i] && !issue);
        if (!en[i]) begin
          m_hi[i] = 0; m_pend[i] = 0; m_ack[i] = 0; m_ok_at[i] = 0;
        end else begin
          if (m_hi[i]) begin
            if (cyc >= m_rise_at[i] + HOLD && (m_ack[i] || eoi[i])) begin
              m_hi[i] = 0; m_ack[i] = 0; m_ok_at[i] = cyc + GAP + 1;
            end else if (eoi[i]) begin
              m_ack[i] = 1;
            end
          end else if (issue) begin
            m_hi[i] = 1; m_rise_at[i] = cyc;
          end
          m_pend[i] = rise || (m_pend[i] && !issue);
        end
      end
      exp_irq[i]  = m_hi[i];
      exp_pend[i] = m_pend[i];
      exp_ovf[i]  = m_ovf[i];
    end
    m_armed = rstn;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare 1 ns later.
  task automatic step(input logic [N-1:0] en, input logic [N-1:0] evt, input logic [N-1:0] eoi,
                      input logic rstn, input logic [N-1:0] oclr);
    bus.EN = en; bus.EVT = evt; bus.EOI = eoi; RSTn = rstn;
`ifdef IRQ_GEN_OVF_EN
    bus.OVF_CLR = oclr;
`endif
    @(posedge CLK);
    model_edge(en, evt, eoi, rstn, oclr);
    cyc++;
    #1;
    chk("irqout", 32'(bus.IRQOUT), 32'(exp_irq));
    chk("pend", 32'(bus.PEND), 32'(exp_pend));
`ifdef IRQ_GEN_OVF_EN
    chk("ovf", 32'(bus.OVF), 32'(exp_ovf));
`endif
    $display("cyc=%0d rstn=%b en=%h evt=%h eoi=%h irqout=%h pend=%h", cyc, rstn, en,
             evt, eoi, bus.IRQOUT, bus.PEND);
  endtask

  localparam logic [N-1:0] ALL = '1;
  localparam logic [N-1:0] NONE = '0;

  initial begin
    int cnt;
    bit found;
    logic [N-1:0] evt_cur, en_r, eoi_r, clr_r;
    bus.EN = '0; bus.EVT = '0; bus.EOI = '0; RSTn = 1'b0;
`ifdef IRQ_GEN_OVF_EN
    bus.OVF_CLR = '0;
`endif

    // Reset with everything asserted, then release with EVT still high.
    for (int k = 0; k < 3; k++) begin
      step(ALL, ALL, NONE, 1'b0, NONE);
      chk("reset_irq_zero", 32'(bus.IRQOUT), 32'd0);
    end
    for (int k = 0; k < 3; k++) step(ALL, ALL, NONE, 1'b1, NONE);
    chk("held_level_no_irq", 32'(bus.IRQOUT | bus.PEND), 32'd0);
    step(ALL, NONE, NONE, 1'b1, NONE);

    // Basic request on channel 0, EOI at t+5.
    step(ALL, 8'h01, NONE, 1'b1, NONE);
    chk("basic_pend_t", 32'(bus.PEND[0]), 32'd1);
    chk("basic_irq_t", 32'(bus.IRQOUT[0]), 32'd0);
    step(ALL, 8'h01, NONE, 1'b1, NONE);
    chk("basic_irq_t1", 32'(bus.IRQOUT[0]), 32'd1);
    for (int k = 0; k < 3; k++) step(ALL, NONE, NONE, 1'b1, NONE);
    step(ALL, NONE, 8'h01, 1'b1, NONE);
    chk("basic_irq_eoi", 32'(bus.IRQOUT[0]), 32'd0);
    chk("basic_pend_eoi", 32'(bus.PEND[0]), 32'd0);

    // Early EOI on channel 2: high exactly HOLD cycles.
    step(ALL, 8'h04, NONE, 1'b1, NONE);
    step(ALL, NONE, NONE, 1'b1, NONE);
    cnt = int'(bus.IRQOUT[2]);
    step(ALL, NONE, 8'h04, 1'b1, NONE);
    cnt += int'(bus.IRQOUT[2]);
    for (int k = 0; k < 6; k++) begin
      step(ALL, NONE, NONE, 1'b1, NONE);
      cnt += int'(bus.IRQOUT[2]);
    end
    chk("early_eoi_high_len", 32'(cnt), 32'(HOLD));

    // Back-to-back on channel 1: second rise during ASSERT, then measure the gap.
    step(ALL, 8'h02, NONE, 1'b1, NONE);
    step(ALL, NONE, NONE, 1'b1, NONE);
    step(ALL, 8'h02, NONE, 1'b1, NONE);
    chk("b2b_pend_queued", 32'(bus.PEND[1]), 32'd1);
    step(ALL, NONE, NONE, 1'b1, NONE);
    step(ALL, NONE, 8'h02, 1'b1, NONE);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(ALL, NONE, NONE, 1'b1, NONE);
      found = (bus.IRQOUT[1] == 1'b0);
    end
    chk("b2b_fall_seen", 32'(found), 32'd1);
    cnt = 1; found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(ALL, NONE, NONE, 1'b1, NONE);
      if (bus.IRQOUT[1]) found = 1; else cnt++;
    end
    chk("b2b_rise_seen", 32'(found), 32'd1);
    // The gap counter runs GAP cycles, then one IDLE cycle issues the queued request.
    chk("b2b_low_len", 32'(cnt), 32'(GAP + 1));
    chk("b2b_pend_cleared", 32'(bus.PEND[1]), 32'd0);

    // Disable channel 3 mid-request with a request queued.
    step(ALL, 8'h08, NONE, 1'b1, NONE);
    step(ALL, 8'h08, NONE, 1'b1, NONE);
    step(ALL, NONE, NONE, 1'b1, NONE);
    step(ALL, 8'h08, NONE, 1'b1, NONE);
    chk("dis_before", 32'({bus.IRQOUT[3], bus.PEND[3]}), 32'd3);
    step(8'hF7, 8'h08, NONE, 1'b1, NONE);
    chk("dis_after", 32'({bus.IRQOUT[3], bus.PEND[3]}), 32'd0);
    step(8'hF7, 8'h08, 8'h08, 1'b1, NONE);
    chk("dis_eoi_ignored", 32'(bus.IRQOUT[3]), 32'd0);
    step(ALL, 8'h08, NONE, 1'b1, NONE);
    chk("reenable_no_event", 32'(bus.PEND[3]), 32'd0);
    step(ALL, NONE, NONE, 1'b1, NONE);

    // Channel 4: two rises while a request is pending.
    step(ALL, 8'h10, NONE, 1'b1, NONE);
    step(ALL, NONE, NONE, 1'b1, NONE);
    step(ALL, 8'h10, NONE, 1'b1, NONE);
    step(ALL, NONE, NONE, 1'b1, NONE);
    step(ALL, 8'h10, NONE, 1'b1, NONE);
    chk("ovf_pend4", 32'(bus.PEND[4]), 32'd1);
`ifdef IRQ_GEN_OVF_EN
    chk("ovf_set", 32'(bus.OVF[4]), 32'd1);
    step(ALL, NONE, NONE, 1'b1, NONE);
    step(ALL, NONE, NONE, 1'b1, NONE);
    chk("ovf_sticky", 32'(bus.OVF[4]), 32'd1);
    step(ALL, NONE, NONE, 1'b1, 8'h10);
    chk("ovf_cleared", 32'(bus.OVF[4]), 32'd0);
`endif

    // Reset while channels are high drops IRQOUT on the next edge.
    step(ALL, NONE, NONE, 1'b0, NONE);
    chk("reset_mid_request", 32'(bus.IRQOUT | bus.PEND), 32'd0);
    step(ALL, NONE, NONE, 1'b1, NONE);

    // Random traffic against the model.
    evt_cur = '0;
    for (int k = 0; k < 800; k++) begin
      evt_cur ^= N'($urandom & $urandom);
      en_r  = ($urandom_range(0, 15) == 0) ? N'($urandom) : ALL;
      eoi_r = N'($urandom & $urandom & $urandom);
      clr_r = N'($urandom & $urandom & $urandom);
      step(en_r, evt_cur, eoi_r, ($urandom_range(0, 199) != 0), clr_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
